// File: rtl/mem_access_stage.sv
// MEM pipeline stage: aligns/extends loads and packs stores over a req/ack data-memory port.
// Optional `define MEM_TIMEOUT_EN adds a 16-cycle WAIT timeout that ends the access with bus_err.
module mem_access_stage #(
    localparam int unsigned XLEN = 32,
    localparam int unsigned BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic            regesterW,
    input  logic [1:0]      regSrc,
    input  logic [4:0]      Rd,
    output logic [XLEN-1:0] reg_write_data_half,
    output logic [XLEN-1:0] Mout,
    output logic            regesterWo,
    output logic [1:0]      regSrco,
    output logic [4:0]      Rdo,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            misalign,
    output logic            bus_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
    logic [BE_W-1:0]   be_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;

    logic              access_c, size_w_c, size_h_c, mis_c;
    logic [BE_W-1:0]   be_c;
    logic [XLEN-1:0]   wdata_c;
    logic              latch_c, capture_c, timeout_c, err_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [XLEN-1:0]   load_c;

    assign reg_write_data_half = alu_result;
    assign regesterWo          = regesterW;
    assign regSrco             = regSrc;
    assign Rdo                 = Rd;

    // Decode size, alignment, byte enables and lane-replicated store data from the live request
    always_comb begin
        access_c = mem_read | mem_write;
        size_w_c = funct3[1];
        size_h_c = ~funct3[1] & funct3[0];
        mis_c    = access_c & ((size_w_c & (|alu_result[1:0])) | (size_h_c & alu_result[0]));
        if (size_w_c) begin
            be_c    = 4'hF;
            wdata_c = store_data;
        end else if (size_h_c) begin
            be_c    = alu_result[1] ? 4'hC : 4'h3;
            wdata_c = {2{store_data[15:0]}};
        end else begin
            be_c    = 4'(4'b0001 << alu_result[1:0]);
            wdata_c = {4{store_data[7:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_c) begin
                addr_q  <= {alu_result[XLEN-1:2], 2'b00};
                wdata_q <= wdata_c;
                be_q    <= be_c;
                we_q    <= mem_write;
                f3_q    <= funct3;
                lo_q    <= alu_result[1:0];
            end
            if (capture_c) rdata_q <= dmem_rdata;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [3:0] cnt_q;
    logic       err_q;

    // Counts ack-less WAIT cycles; the 16th one abandons the access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == WAIT && !dmem_ack) cnt_q <= cnt_q + 4'd1;
            else                              cnt_q <= '0;
            if (latch_c)        err_q <= 1'b0;
            else if (timeout_c) err_q <= 1'b1;
        end
    end

    assign timeout_c = (state_q == WAIT) && !dmem_ack && (cnt_q == 4'hF);
    assign err_c     = err_q;
    assign bus_err   = (state_q == DONE) && err_q;
`else
    assign timeout_c = 1'b0;
    assign err_c     = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = '0;
        stall      = 1'b0;
        misalign   = 1'b0;
        latch_c    = 1'b0;
        capture_c  = 1'b0;
        case (state_q)
            IDLE: begin
                // rst gates the live-input path so reset forces the bus quiet at once
                if (rst && access_c) begin
                    if (mis_c) begin
                        misalign = 1'b1;
                    end else begin
                        dmem_req   = 1'b1;
                        dmem_we    = mem_write;
                        dmem_addr  = {alu_result[XLEN-1:2], 2'b00};
                        dmem_wdata = wdata_c;
                        dmem_be    = be_c;
                        stall      = 1'b1;
                        latch_c    = 1'b1;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                dmem_be    = be_q;
                stall      = 1'b1;
                if (dmem_ack) begin
                    capture_c = 1'b1;
                    state_d   = DONE;
                end else if (timeout_c) begin
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane select and sign/zero extension of the captured read word
    always_comb begin
        case (lo_q)
            2'd0:    byte_c = rdata_q[7:0];
            2'd1:    byte_c = rdata_q[15:8];
            2'd2:    byte_c = rdata_q[23:16];
            default: byte_c = rdata_q[31:24];
        endcase
        half_c = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        if (f3_q[1])      load_c = rdata_q;
        else if (f3_q[0]) load_c = {{16{half_c[15] & ~f3_q[2]}}, half_c};
        else              load_c = {{24{byte_c[7] & ~f3_q[2]}}, byte_c};
        Mout = (state_q == DONE && !we_q && !err_c) ? load_c : '0;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have alu_result  input  32  effective address / non-load writeback value from EX/MEM.
REQ-004 SHALL have store_data  input  32  rs2 value for stores.
REQ-005 SHALL have mem_read, mem_write  input  1 each  load / store request.
REQ-006 SHALL have funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have regesterW  input  1, regSrc  input  2, Rd  input  5  writeback sideband.
REQ-008 SHALL have reg_write_data_half  output  32  equals alu_result, combinational.
REQ-009 SHALL have Mout  output  32  aligned, extended load data.
REQ-010 SHALL have regesterWo  output  1, regSrco  output  2, Rdo  output  5  combinational passthrough of sideband.
REQ-011 SHALL have stall  output  1  freezes upstream registers and the MEM/WB register.
REQ-012 SHALL have dmem_req, dmem_we  output  1; dmem_addr  output  32 (bits[1:0]=0); dmem_wdata  output  32; dmem_be  output  4.
REQ-013 SHALL have dmem_rdata  input  32, dmem_ack  input  1.
REQ-014 SHALL have misalign  output  1, bus_err  output  1  single-cycle status pulses.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, DONE; reset state IDLE.
REQ-016 IDLE with mem_read|mem_write and aligned access: dmem_req=1, bus driven from inputs, stall=1, bus fields latched; next WAIT.
REQ-017 WAIT: dmem_req=1, bus driven from latched copy (stable), stall=1; dmem_ack=1 captures dmem_rdata, next DONE; dmem_ack in IDLE/DONE ignored.
REQ-018 DONE: dmem_req=0, stall=0, Mout from captured data; next IDLE unconditionally.
REQ-019 Minimum latency: request cycle + ack cycle + DONE; stall high exactly 2 cycles when ack arrives in the first WAIT cycle.
REQ-020 Loads: byte lane selected by addr[1:0], half by addr[1]; B/H sign-extend, BU/HU zero-extend; funct3 011/110/111 treated as W.
REQ-021 Stores: SB be=0001<<addr[1:0], byte replicated across all lanes; SH be=0011 or 1100, half replicated; SW be=1111.
REQ-022 Mout SHALL be 0 in IDLE/WAIT, for stores, and for non-memory instructions.
REQ-023 Misaligned (H with addr[0]=1, W with addr[1:0]!=0): no request, misalign=1 for one cycle, stall=0, Mout=0, store suppressed.
REQ-024 mem_read and mem_write both set: treated as store; Mout=0.

Reset
REQ-025 rst low SHALL immediately force IDLE, dmem_req=0, dmem_we=0, dmem_be=0, stall=0, misalign=0, bus_err=0, captured data/latched bus/counter=0, Mout=0.
REQ-026 Reset mid-WAIT SHALL abandon the transaction; a late dmem_ack after release SHALL be ignored.

Configuration
REQ-027 With MEM_TIMEOUT_EN defined: 4-bit counter in WAIT; 16 cycles without ack -> leave WAIT to DONE, Mout=0, bus_err=1 for one cycle, store counted lost.
REQ-028 Without MEM_TIMEOUT_EN: WAIT held indefinitely; bus_err tied 0; no counter logic.

Verification
REQ-029 LB addr=0x103, rdata=0x80FF_0000, ack in 1st WAIT cycle -> stall 2 cycles, DONE Mout=0xFFFF_FF80.
REQ-030 SH addr=0x202, store_data=0x0000_ABCD, ack after 3 WAIT cycles -> be=1100, wdata=0xABCD_ABCD, dmem_we=1, addr=0x200 stable all WAIT cycles, stall 4 cycles.
REQ-031 LW addr=0x101 -> dmem_req never asserted, misalign pulse, stall=0, Mout=0.
REQ-032 LHU addr=0x2, rdata=0xBEEF_1234, rst pulsed low in WAIT, ack after release -> FSM IDLE, ack ignored, outputs 0.
REQ-033 MEM_TIMEOUT_EN, LW with no ack -> 16 WAIT cycles, DONE with bus_err=1, Mout=0; without macro -> stall held high through 100 cycles.
REQ-034 Non-memory op alu_result=0x1234, Rd=5 -> stall=0, reg_write_data_half=0x1234, Rdo=5, Mout=0.
